// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and anything that
// integrates or exercises it.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  // Arbiter FSM: idle, or one transaction in flight for CPU or loader.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_C = 2'd1,
    GRANT_L = 2'd2
  } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU read/write, loader write) arbiter in front
// of a single memory port with wait states. Round-robin on ties, one
// transaction in flight, one-cycle done pulse per requester.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  CPU request (held until c_done)
//   c_rdata, c_done         CPU read data (valid with c_done) and done pulse
//   l_req/l_addr/l_wdata    loader write request (held until l_done)
//   l_done                  loader done pulse
//   m_req/m_we/m_addr/m_wdata  memory request, stable for the whole grant
//   m_rdata, m_ack          memory read data and completion
//   err                     sticky timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort a grant after TIMEOUT_CYC
// cycles without m_ack (CPU reads then return all-ones and err is set).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W      = MEM_ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_l;   // 1: loader was granted last
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic              r_c_done;
  logic              r_l_done;
  logic              w_c_elig;
  logic              w_l_elig;
  logic              w_grant_c;
  logic              w_grant_l;
  logic              w_finish;
  logic              w_tmo;

  assign m_req   = (r_state != IDLE);
  assign m_we    = r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign c_rdata = r_c_rdata;
  assign c_done  = r_c_done;
  assign l_done  = r_l_done;

  // Grant cycle timeout (abort path)
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_tmo = (r_state != IDLE) && !m_ack &&
                 (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == IDLE || w_finish) r_tmo_cnt <= '0;
      else                             r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      if (w_tmo) r_err <= 1'b1;
    end
  end
`else
  // TIMEOUT_CYC has no effect in this build; grants wait for m_ack forever.
  localparam bit TMO_CFG_ZERO = (TIMEOUT_CYC == 0);

  assign w_tmo = 1'b0;
  assign err   = 1'b0 & TMO_CFG_ZERO;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a requester whose done is pulsing this cycle is not eligible
  always_comb begin
    w_state_nxt = r_state;
    w_grant_c   = 1'b0;
    w_grant_l   = 1'b0;
    w_finish    = 1'b0;
    w_c_elig    = c_req && !r_c_done;
    w_l_elig    = l_req && !r_l_done;
    case (r_state)
      IDLE: begin
        if (w_c_elig && (!w_l_elig || r_last_l)) begin
          w_grant_c   = 1'b1;
          w_state_nxt = GRANT_C;
        end else if (w_l_elig) begin
          w_grant_l   = 1'b1;
          w_state_nxt = GRANT_L;
        end
      end
      GRANT_C, GRANT_L: begin
        if (m_ack || w_tmo) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, done pulses, CPU read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_c_done  <= 1'b0;
      r_l_done  <= 1'b0;
    end else begin
      r_c_done <= w_finish && (r_state == GRANT_C);
      r_l_done <= w_finish && (r_state == GRANT_L);
      if (w_grant_c) begin
        r_last_l <= 1'b0;
        r_we     <= c_we;
        r_addr   <= c_addr;
        r_wdata  <= c_wdata;
      end else if (w_grant_l) begin
        r_last_l <= 1'b1;
        r_we     <= 1'b1;
        r_addr   <= l_addr;
        r_wdata  <= l_wdata;
      end
      // An aborted read returns all-ones
      if (w_finish && (r_state == GRANT_C) && !r_we)
        r_c_rdata <= m_ack ? m_rdata : '1;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, loader write, async reset
// mid-grant, round-robin, spurious ack / held request, timeout behaviour.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW  = MEM_ARB_ADDR_W;
  localparam int unsigned DW  = MEM_ARB_DATA_W;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, c_done;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_done;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_addr = '0; l_wdata = '0;
    m_ack = 0; m_rdata = '0;
    tick(); tick();
    total++; if ({m_req, c_done, l_done, err, m_we} !== 5'b0) begin bad++;
      $display("FAIL rst_ctrl: {m_req,c_done,l_done,err,m_we}=%b want 00000", {m_req, c_done, l_done, err, m_we}); end
    total++; if (c_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", c_rdata); end
    total++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin bad++;
      $display("FAIL rst_maddr: addr=%h wdata=%h want 0/0", m_addr, m_wdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    c_req = 1; c_we = 0; c_addr = 32'h40;
    tick();
    total++; if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h40) begin bad++;
      $display("FAIL rd_grant: m_req=%b m_we=%b m_addr=%h want 1/0/40", m_req, m_we, m_addr); end
    tick();
    total++; if (m_req !== 1'b1 || c_done !== 1'b0) begin bad++;
      $display("FAIL rd_wait: m_req=%b c_done=%b want 1/0", m_req, c_done); end
    m_ack = 1; m_rdata = 32'h1234_5678;
    tick();
    m_ack = 0;
    total++; if (c_done !== 1'b1 || l_done !== 1'b0 || m_req !== 1'b0) begin bad++;
      $display("FAIL rd_done: c_done=%b l_done=%b m_req=%b want 1/0/0", c_done, l_done, m_req); end
    total++; if (c_rdata !== 32'h1234_5678) begin bad++;
      $display("FAIL rd_data: got %h want 12345678", c_rdata); end
    c_req = 0;
    tick();
    total++; if (c_done !== 1'b0 || m_req !== 1'b0) begin bad++;
      $display("FAIL rd_pulse: c_done=%b m_req=%b want 0/0", c_done, m_req); end
  endtask

  task automatic test_loader_write();
    l_req = 1; l_addr = 32'h100; l_wdata = 32'hCAFE_F00D;
    tick();
    l_addr = 32'h0BAD; l_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      total++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h100 || m_wdata !== 32'hCAFE_F00D) begin bad++;
        $display("FAIL ld_stable%0d: req=%b we=%b addr=%h wdata=%h want 1/1/100/cafef00d", i, m_req, m_we, m_addr, m_wdata); end
      tick();
    end
    m_ack = 1;
    tick();
    m_ack = 0; l_req = 0;
    total++; if (l_done !== 1'b1 || c_done !== 1'b0 || m_req !== 1'b0) begin bad++;
      $display("FAIL ld_done: l_done=%b c_done=%b m_req=%b want 1/0/0", l_done, c_done, m_req); end
    tick();
    total++; if (l_done !== 1'b0) begin bad++; $display("FAIL ld_once: l_done=%b want 0", l_done); end
  endtask

  task automatic test_reset_mid_grant();
    c_req = 1; c_we = 0; c_addr = 32'h44;
    tick();
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL mid_grant: m_req=%b want 1", m_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_req !== 1'b0 || c_done !== 1'b0) begin bad++;
      $display("FAIL mid_async: m_req=%b c_done=%b want 0/0", m_req, c_done); end
    tick();
    total++; if (c_done !== 1'b0) begin bad++; $display("FAIL mid_nodone: c_done=%b want 0", c_done); end
    l_req = 1; l_addr = 32'h200; l_wdata = 32'h1;
    rst_n = 1'b1;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h44) begin bad++;
      $display("FAIL mid_tie_cpu: m_req=%b m_addr=%h want 1/44", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h55;
    tick();
    c_req = 0;
    total++; if (c_done !== 1'b1 || l_done !== 1'b0 || c_rdata !== 32'h55) begin bad++;
      $display("FAIL mid_cdone: c_done=%b l_done=%b c_rdata=%h want 1/0/55", c_done, l_done, c_rdata); end
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h200 || c_done !== 1'b0) begin bad++;
      $display("FAIL mid_lgrant: m_req=%b m_addr=%h c_done=%b want 1/200/0", m_req, m_addr, c_done); end
    tick();
    total++; if (l_done !== 1'b1 || c_done !== 1'b0) begin bad++;
      $display("FAIL mid_ldone: l_done=%b c_done=%b want 1/0", l_done, c_done); end
    l_req = 0; m_ack = 0;
    tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hA;
    l_req = 1; l_addr = 32'h20; l_wdata = 32'hB;
    m_ack = 1;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h10 || m_wdata !== 32'hA) begin bad++;
      $display("FAIL rr_first_cpu: m_req=%b addr=%h wdata=%h want 1/10/a", m_req, m_addr, m_wdata); end
    tick();
    total++; if (c_done !== 1'b1 || l_done !== 1'b0 || m_req !== 1'b0) begin bad++;
      $display("FAIL rr_cdone1: c_done=%b l_done=%b m_req=%b want 1/0/0", c_done, l_done, m_req); end
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h20 || m_we !== 1'b1 || c_done !== 1'b0) begin bad++;
      $display("FAIL rr_loader: m_req=%b addr=%h we=%b c_done=%b want 1/20/1/0", m_req, m_addr, m_we, c_done); end
    tick();
    total++; if (l_done !== 1'b1 || c_done !== 1'b0) begin bad++;
      $display("FAIL rr_ldone: l_done=%b c_done=%b want 1/0", l_done, c_done); end
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h10) begin bad++;
      $display("FAIL rr_cpu_again: m_req=%b addr=%h want 1/10", m_req, m_addr); end
    tick();
    total++; if (c_done !== 1'b1 || l_done !== 1'b0) begin bad++;
      $display("FAIL rr_cdone2: c_done=%b l_done=%b want 1/0", c_done, l_done); end
    c_req = 0; l_req = 0; m_ack = 0;
    tick();
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rr_idle: m_req=%b want 0", m_req); end
  endtask

  task automatic test_rr_pointer();
    // CPU was granted last, so the loader wins this tie
    c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'h3;
    l_req = 1; l_addr = 32'h31; l_wdata = 32'h4;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h31 || m_wdata !== 32'h4) begin bad++;
      $display("FAIL ptr_loader: m_req=%b addr=%h wdata=%h want 1/31/4", m_req, m_addr, m_wdata); end
    m_ack = 1;
    tick();
    l_req = 0; m_ack = 0;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h30) begin bad++;
      $display("FAIL ptr_cpu: m_req=%b addr=%h want 1/30", m_req, m_addr); end
    m_ack = 1;
    tick();
    c_req = 0; m_ack = 0;
    total++; if (c_done !== 1'b1) begin bad++; $display("FAIL ptr_cdone: c_done=%b want 1", c_done); end
    tick();
  endtask

  task automatic test_spurious_ack();
    m_ack = 1; m_rdata = 32'h0BAD;
    tick(); tick();
    total++; if (m_req !== 1'b0 || c_done !== 1'b0 || l_done !== 1'b0 || c_rdata !== 32'h0) begin bad++;
      $display("FAIL sp_ignored: m_req=%b c_done=%b l_done=%b c_rdata=%h want 0/0/0/0", m_req, c_done, l_done, c_rdata); end
    m_ack = 0;
    c_req = 1; c_we = 0; c_addr = 32'h80;
    tick();
    total++; if (m_req !== 1'b1 || m_addr !== 32'h80) begin bad++;
      $display("FAIL sp_grant: m_req=%b addr=%h want 1/80", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h9;
    tick();
    m_ack = 0;
    total++; if (c_done !== 1'b1 || c_rdata !== 32'h9) begin bad++;
      $display("FAIL sp_done: c_done=%b c_rdata=%h want 1/9", c_done, c_rdata); end
    tick();
    total++; if (m_req !== 1'b0 || c_done !== 1'b0) begin bad++;
      $display("FAIL sp_no_regrant: m_req=%b c_done=%b want 0/0", m_req, c_done); end
    c_req = 0;
    tick();
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL sp_released: m_req=%b want 0", m_req); end
    // A CPU write leaves c_rdata alone
    c_req = 1; c_we = 1; c_addr = 32'h84; c_wdata = 32'h77;
    tick();
    total++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'h77) begin bad++;
      $display("FAIL wr_grant: m_req=%b we=%b wdata=%h want 1/1/77", m_req, m_we, m_wdata); end
    m_ack = 1; m_rdata = 32'hDEAD;
    tick();
    c_req = 0; m_ack = 0;
    total++; if (c_done !== 1'b1 || c_rdata !== 32'h9) begin bad++;
      $display("FAIL wr_keep_rdata: c_done=%b c_rdata=%h want 1/9", c_done, c_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    c_req = 1; c_we = 0; c_addr = 32'hC0;
    tick();
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL to_grant: m_req=%b want 1", m_req); end
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i < int'(TMO); i++) begin
      tick();
      total++; if (m_req !== 1'b1 || c_done !== 1'b0) begin bad++;
        $display("FAIL to_wait%0d: m_req=%b c_done=%b want 1/0", i, m_req, c_done); end
    end
    tick();
    total++; if (c_done !== 1'b1 || m_req !== 1'b0 || c_rdata !== 32'hFFFF_FFFF || err !== 1'b1) begin bad++;
      $display("FAIL to_abort: c_done=%b m_req=%b c_rdata=%h err=%b want 1/0/ffffffff/1", c_done, m_req, c_rdata, err); end
    c_req = 0;
    tick();
    total++; if (err !== 1'b1 || c_done !== 1'b0) begin bad++;
      $display("FAIL to_sticky: err=%b c_done=%b want 1/0", err, c_done); end
`else
    for (int i = 1; i <= int'(TMO) + 4; i++) begin
      tick();
      total++; if (m_req !== 1'b1 || c_done !== 1'b0 || err !== 1'b0) begin bad++;
        $display("FAIL to_hold%0d: m_req=%b c_done=%b err=%b want 1/0/0", i, m_req, c_done, err); end
    end
    c_req = 0;
`endif
    apply_reset();
    total++; if (err !== 1'b0 || m_req !== 1'b0) begin bad++;
      $display("FAIL to_reset: err=%b m_req=%b want 0/0", err, m_req); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_loader_write();
    test_reset_mid_grant();
    test_round_robin();
    test_rr_pointer();
    test_spurious_ack();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
